// File: rtl/blink_game_ctrl.sv
// blink_game_ctrl: sequencer for the LED-blink reaction game. Walks a one-hot LED
// on each sclk rising edge, judges debounced presses against TARGET, keeps score.
// Ports: clk, rst_n (async low), btn (async level), sclk (blink clock),
//        score[3:0], led[N_LEDS-1:0], state[2:0], win, game_over, lives[1:0].
// Optional: define BLINK_LIVES_EN for the lives / game-over mode.
module blink_game_ctrl #(
    parameter int N_LEDS       = 8,
    parameter int TARGET       = 7,
    parameter int MAX_SCORE    = 10,
    parameter int FLASH_CYCLES = 50000000,
    parameter int LIVES        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    input  logic              sclk,
    output logic [3:0]        score,
    output logic [N_LEDS-1:0] led,
    output logic [2:0]        state,
    output logic              win,
    output logic              game_over,
    output logic [1:0]        lives
);

    localparam int PW = $clog2(N_LEDS);
    localparam int CW = $clog2(FLASH_CYCLES + 1);

    localparam logic [PW-1:0] POS_LAST  = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_TGT   = PW'(TARGET);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FLASH_CYCLES - 1);
    localparam logic [3:0]    SCORE_MAX = 4'(MAX_SCORE);
    localparam logic [1:0]    LIVES_RLD = 2'(LIVES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_HIT   = 3'd2;
    localparam logic [2:0] S_MISS  = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    logic btn_s1_q, btn_s2_q, btn_prev_q, sclk_q;
    logic press, step;

    logic [2:0]        state_q, state_d;
    logic [3:0]        score_q, score_d, score_inc;
    logic [PW-1:0]     pos_q, pos_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              win_q, win_d;
    logic              over_q, over_d;
    logic [1:0]        lives_q, lives_d;

    assign press = btn_s2_q & ~btn_prev_q;
    assign step  = sclk & ~sclk_q;

    // Saturating increment: score never passes MAX_SCORE.
    assign score_inc = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 4'd1;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        lives_d = lives_q;
        unique case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_RUN;
                    score_d = 4'd0;
                    pos_d   = '0;
                    lives_d = LIVES_RLD;
                end
            end
            S_RUN: begin
                // A press wins over a coincident step: judged on the old pos.
                if (press) begin
                    cnt_d = '0;
                    if (pos_q == POS_TGT) begin
                        score_d = score_inc;
                        state_d = (score_inc == SCORE_MAX) ? S_WIN : S_HIT;
                    end else begin
                        state_d = S_MISS;
`ifdef BLINK_LIVES_EN
                        lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
`else
                        score_d = 4'd0;
`endif
                    end
                end else if (step) begin
                    pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                end
            end
            S_HIT, S_MISS: begin
                if (cnt_q == CNT_LAST) begin
                    pos_d   = '0;
                    state_d = S_RUN;
`ifdef BLINK_LIVES_EN
                    if (state_q == S_MISS && lives_q == 2'd0) begin
                        state_d = S_OVER;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WIN, S_OVER: begin
                if (press) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next state so they move on the transition edge.
    always_comb begin
        led_d = '0;
        unique case (state_d)
            S_RUN:        led_d[pos_d] = 1'b1;
            S_HIT, S_WIN: led_d = '1;
            default:      led_d = '0;
        endcase
        win_d  = (state_d == S_WIN);
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            sclk_q     <= 1'b0;
            state_q    <= S_IDLE;
            score_q    <= 4'd0;
            pos_q      <= '0;
            cnt_q      <= '0;
            led_q      <= '0;
            win_q      <= 1'b0;
            over_q     <= 1'b0;
`ifdef BLINK_LIVES_EN
            lives_q    <= LIVES_RLD;
`else
            lives_q    <= 2'd0;
`endif
        end else begin
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            sclk_q     <= sclk;
            state_q    <= state_d;
            score_q    <= score_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            win_q      <= win_d;
            over_q     <= over_d;
`ifdef BLINK_LIVES_EN
            lives_q    <= lives_d;
`else
            lives_q    <= 2'd0;
`endif
        end
    end

    assign score     = score_q;
    assign led       = led_q;
    assign state     = state_q;
    assign win       = win_q;
    assign game_over = over_q;
    assign lives     = lives_q;

endmodule

// File: tb/tb_blink_game_ctrl.sv
// tb_blink_game_ctrl: directed bench for blink_game_ctrl
// with N_LEDS=4, TARGET=3, MAX_SCORE=2, FLASH_CYCLES=5, LIVES=2.
module tb_blink_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       sclk;
    logic [3:0] score;
    logic [3:0] led;
    logic [2:0] state;
    logic       win;
    logic       game_over;
    logic [1:0] lives;

    int n_chk = 0;
    int n_err = 0;

    blink_game_ctrl #(
        .N_LEDS(4), .TARGET(3), .MAX_SCORE(2),
        .FLASH_CYCLES(5), .LIVES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .sclk(sclk),
        .score(score), .led(led), .state(state), .win(win),
        .game_over(game_over), .lives(lives)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_led(input string tag, input int exp);
        sclk = 1'b1;
        tick(1);
        chk(tag, int'(led), exp);
        sclk = 1'b0;
        tick(1);
    endtask

    task automatic press3;
        btn = 1'b1;
        tick(3);
    endtask

    task automatic release3;
        btn = 1'b0;
        tick(3);
    endtask

`ifdef BLINK_LIVES_EN
    localparam int RST_LIVES = 2;
`else
    localparam int RST_LIVES = 0;
`endif

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        sclk  = 1'b0;
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_lives", int'(lives), RST_LIVES);
        rst_n = 1'b1;
        tick(1);

        // 1: start, walk with btn held (no second press)
        btn = 1'b1;
        tick(2);
        chk("t1_pre", int'(state), 0);
        tick(1);
        chk("t1_state", int'(state), 1);
        chk("t1_led", int'(led), 1);
        chk("t1_score", int'(score), 0);
        step_led("t1_w1", 2);
        step_led("t1_w2", 4);
        step_led("t1_w3", 8);
        step_led("t1_wrap", 1);
        chk("t1_held", int'(state), 1);
        release3();

        // 2: hit, flash length, press ignored during flash
        step_led("t2_w1", 2);
        step_led("t2_w2", 4);
        step_led("t2_w3", 8);
        press3();
        chk("t2_score", int'(score), 1);
        chk("t2_state", int'(state), 2);
        chk("t2_led", int'(led), 15);
        btn = 1'b0;
        tick(1);
        btn = 1'b1;
        tick(3);
        chk("t2_fl4", int'(state), 2);
        chk("t2_fl4led", int'(led), 15);
        btn = 1'b0;
        tick(1);
        chk("t2_exit", int'(state), 1);
        chk("t2_exitled", int'(led), 1);
        chk("t2_keep", int'(score), 1);
        tick(2);

        // 3: winning hit, WIN holds, press returns to IDLE
        step_led("t3_w1", 2);
        step_led("t3_w2", 4);
        step_led("t3_w3", 8);
        press3();
        chk("t3_score", int'(score), 2);
        chk("t3_state", int'(state), 4);
        chk("t3_win", int'(win), 1);
        chk("t3_led", int'(led), 15);
        release3();
        chk("t3_hold", int'(state), 4);
        chk("t3_sat", int'(score), 2);
        press3();
        chk("t3_idle", int'(state), 0);
        chk("t3_idleled", int'(led), 0);
        chk("t3_nowin", int'(win), 0);
        release3();

`ifndef BLINK_LIVES_EN
        // 4: miss clears score
        press3();
        chk("t4_run", int'(state), 1);
        chk("t4_sc0", int'(score), 0);
        release3();
        step_led("t4_w1", 2);
        step_led("t4_w2", 4);
        step_led("t4_w3", 8);
        press3();
        chk("t4_hit", int'(score), 1);
        btn = 1'b0;
        tick(5);
        chk("t4_back", int'(state), 1);
        step_led("t4_w4", 2);
        press3();
        chk("t4_miss", int'(state), 3);
        chk("t4_clr", int'(score), 0);
        chk("t4_led", int'(led), 0);
        btn = 1'b0;
        tick(4);
        chk("t4_fl4", int'(state), 3);
        tick(1);
        chk("t4_exit", int'(state), 1);
        chk("t4_exitled", int'(led), 1);
        chk("t4_over", int'(game_over), 0);
        chk("t4_lives", int'(lives), 0);
        tick(2);
`else
        // 5: lives run out, OVER, restart reloads lives
        press3();
        chk("t5_run", int'(state), 1);
        chk("t5_lives", int'(lives), 2);
        release3();
        step_led("t5_w1", 2);
        step_led("t5_w2", 4);
        step_led("t5_w3", 8);
        press3();
        chk("t5_hit", int'(score), 1);
        btn = 1'b0;
        tick(5);
        step_led("t5_w4", 2);
        press3();
        chk("t5_miss1", int'(state), 3);
        chk("t5_keep", int'(score), 1);
        chk("t5_l1", int'(lives), 1);
        btn = 1'b0;
        tick(5);
        chk("t5_back", int'(state), 1);
        step_led("t5_w5", 2);
        press3();
        chk("t5_l0", int'(lives), 0);
        btn = 1'b0;
        tick(5);
        chk("t5_over", int'(state), 5);
        chk("t5_go", int'(game_over), 1);
        chk("t5_oled", int'(led), 0);
        press3();
        chk("t5_idle", int'(state), 0);
        chk("t5_go0", int'(game_over), 0);
        release3();
        press3();
        chk("t5_rerun", int'(state), 1);
        chk("t5_reload", int'(lives), 2);
        release3();
`endif

        // 6: press and step together at pos 3, then async reset mid-flash
        step_led("t6_w1", 2);
        step_led("t6_w2", 4);
        step_led("t6_w3", 8);
        btn = 1'b1;
        tick(2);
        sclk = 1'b1;
        tick(1);
        chk("t6_state", int'(state), 2);
        chk("t6_score", int'(score), 1);
        chk("t6_led", int'(led), 15);
        sclk = 1'b0;
        btn  = 1'b0;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rstate", int'(state), 0);
        chk("t6_rled", int'(led), 0);
        chk("t6_rscore", int'(score), 0);
        chk("t6_rwin", int'(win), 0);
        chk("t6_rgo", int'(game_over), 0);
        chk("t6_rlives", int'(lives), RST_LIVES);
        rst_n = 1'b1;
        press3();
        chk("t6_restart", int'(state), 1);
        chk("t6_restled", int'(led), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/blink_game_ctrl.md
Name: blink_game_ctrl

Overview:
- Game sequencer for the LED-blink reaction game.
- Walks a one-hot LED across the board on each rising edge of the divided blink clock `sclk`, which comes from the blink-speed divider.
- Judges player button presses against a target LED position and keeps the score.
- Drives the 4-bit `score` back into the divider, so each hit speeds up the blink.

Parameters:
- N_LEDS, 8, number of LEDs in the walking pattern (2..16).
- TARGET, 7, LED index a press must coincide with to score (0..N_LEDS-1).
- MAX_SCORE, 10, score that wins the game (1..10; keeps divider count positive).
- FLASH_CYCLES, 50000000, clk cycles spent in HIT_FLASH / MISS_FLASH (>=1).
- LIVES, 3, starting lives when LIVES_EN is defined (1..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  1  player button, level, asynchronous, pre-debounced externally.
- sclk  in  1  divided blink clock from the divider, registered in the clk domain.
- score  out  4  current score, fed to the divider.
- led  out  N_LEDS  LED drive.
- state  out  3  FSM state code.
- win  out  1  high while in WIN.
- game_over  out  1  high while in OVER.
- lives  out  2  remaining lives (constant 0 without LIVES_EN).

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE(0), score=0, led=0, pos=0, flash counter=0, win=0, game_over=0.
  - lives=LIVES with LIVES_EN, 0 without.
  - All synchronizer and edge registers clear.
  - Release is synchronous to clk.
- btn input: two-flop synchronizer, then rising-edge detect.
  - press pulse is high exactly 1 cycle.
  - First acted on 3 clk edges after btn is first sampled high.
  - Holding btn gives one press only.
- step pulse = sclk & ~sclk_q. One pulse per sclk rising edge, 1 cycle wide.
- FSM states: IDLE=0, RUN=1, HIT_FLASH=2, MISS_FLASH=3, WIN=4, OVER=5.
- IDLE:
  - led=0.
  - press -> RUN; score=0, pos=0, lives reloaded to LIVES.
- RUN:
  - led = one-hot at pos.
  - step with no press: pos=pos+1, wrapping N_LEDS-1 -> 0.
  - press with pos==TARGET:
    - score+1.
    - If the new score==MAX_SCORE -> WIN.
    - Otherwise -> HIT_FLASH.
  - press with pos!=TARGET: -> MISS_FLASH.
  - press and step in the same cycle: the press is judged on the pre-step pos, and pos does not advance.
- HIT_FLASH: led all ones; flash counter counts FLASH_CYCLES cycles, then -> RUN with pos=0.
- MISS_FLASH:
  - led=0.
  - Without LIVES_EN: score cleared to 0 on entry.
  - After FLASH_CYCLES cycles: -> RUN with pos=0 (but see LIVES_EN).
- In both flash states, press and step are ignored.
- WIN: led all ones, win=1; score held. press -> IDLE.
- OVER: led=0, game_over=1. press -> IDLE.
- Output timing:
  - All outputs are registered and change on the same edge as the state transition.
  - score is saturating: never exceeds MAX_SCORE, never wraps.
- Flash counter:
  - Width is $clog2(FLASH_CYCLES+1).
  - Cleared on flash entry; exits when count==FLASH_CYCLES-1.
- Reset mid-flash or mid-run returns to IDLE immediately; the current game is discarded.

Optional Feature:
- Macro: BLINK_LIVES_EN.
- Defined:
  - A miss leaves score unchanged and decrements lives on entry to MISS_FLASH.
  - If lives becomes 0, MISS_FLASH exits to OVER instead of RUN.
  - Entering IDLE->RUN reloads lives=LIVES.
- Undefined:
  - A miss clears score to 0.
  - OVER is unreachable; game_over=0 and lives=0 constantly.

Test Plan (N_LEDS=4, TARGET=3, MAX_SCORE=2, FLASH_CYCLES=5):
1. Reset, press btn -> 3 edges later state=1, led=4'b0001, score=0; four sclk rising edges -> led 0010, 0100, 1000, 0001.
2. In RUN at led=1000, press -> score=1, state=2, led=1111 for 5 cycles, then state=1, led=0001; a press during the flash is ignored.
3. Hit at score=1 -> score=2, state=4, win=1, led=1111; press -> state=0, led=0, win=0.
4. Without BLINK_LIVES_EN: score=1, press at led=0010 -> state=3, score=0, led=0 for 5 cycles, then state=1.
5. With BLINK_LIVES_EN, LIVES=2: miss twice -> lives 2->1->0, after the second flash state=5, game_over=1; press -> IDLE; press -> RUN, lives=2.
6. A press and an sclk rising edge land in the same cycle with led=1000 -> scored as a hit, pos not advanced. Separately, assert rst_n low mid-HIT_FLASH -> all outputs at reset values immediately, without waiting for clk.
